// File: rtl/mem_access_stage_pkg.sv
// mem_pkg: shared state, encoding constants and issue-entry layout for the memory access stage
package mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_STORE  = 1'b1;
    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic [31:0] addr;
        logic        ls;
        logic        size;
        logic [31:0] swData;
        logic        fromLSQ;
        logic [31:0] lwData;
    } entry_t;
endpackage

// File: rtl/mem_access_stage_issue_fifo.sv
// issue_fifo: synchronous FIFO of issue entries; simultaneous push and pop are both honoured
module issue_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    entry_t mem [DEPTH];
    logic [PW-1:0] wr, rd;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            wr    <= wr + PW'(do_push);
            rd    <= rd + PW'(do_pop);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: buffered data-memory stage with fixed-latency RAM and forwarded-load bypass
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inValid,
    input  logic [31:0] inPc,
    input  logic [5:0]  inROBNum,
    input  logic [5:0]  inDestReg,
    input  logic [31:0] inAddr,
    input  logic        inLoadStore,
    input  logic        inSize,
    input  logic [31:0] inSwData,
    input  logic        inFromLSQ,
    input  logic [31:0] inLwData,
    output logic        wbValid,
    output logic [31:0] wbPc,
    output logic [5:0]  wbROBNum,
    output logic [5:0]  wbDestReg,
    output logic [31:0] wbData,
    output logic        wbIsStore,
    output logic        fifoFull,
    output logic        overflowErr,
    output logic        misalignErr
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    entry_t in_entry, head, op;
    state_t state;
    logic [CW-1:0] cnt;
    logic [PW:0] count;
    logic full, empty, pop, fwd, ram_op;
    logic [31:0] ram [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [1:0] lane;
    logic [31:0] rd_word, ld_data;
    logic [7:0] rd_byte;
    logic unused_bits;
    assign in_entry = '{pc: inPc, rob: inROBNum, dest: inDestReg, addr: inAddr, ls: inLoadStore,
                        size: inSize, swData: inSwData, fromLSQ: inFromLSQ, lwData: inLwData};
    assign pop      = state == IDLE && !empty;
    assign fwd      = head.fromLSQ && head.ls == OP_LOAD;
    assign fifoFull = count == (PW+1)'(FIFO_DEPTH);
    assign wbValid  = state == RESP;
    issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rstn(rstn), .push(inValid), .pop(pop), .din(in_entry),
        .dout(head), .full(full), .empty(empty), .count(count)
    );
    // Upper address bits wrap away; fields consumed only at pop are not needed from op.
    assign unused_bits = ^{op.addr[31:AW+2], op.fromLSQ, op.lwData};
    assign ram_op  = state == ACCESS && cnt == CW'(1);
    assign idx     = op.addr[AW+1:2];
    assign lane    = op.addr[1:0];
    assign rd_word = ram[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_data = op.size == SIZE_BYTE ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            wbPc        <= '0;
            wbROBNum    <= '0;
            wbDestReg   <= '0;
            wbData      <= '0;
            wbIsStore   <= 1'b0;
            overflowErr <= 1'b0;
            misalignErr <= 1'b0;
        end else begin
            overflowErr <= overflowErr | (inValid & full & ~pop);
            if (pop) begin
                op    <= head;
                state <= fwd ? RESP : ACCESS;
                cnt   <= CW'(MEM_LATENCY);
                if (fwd) begin
                    wbPc      <= head.pc;
                    wbROBNum  <= head.rob;
                    wbDestReg <= head.dest;
                    wbData    <= head.lwData;
                    wbIsStore <= 1'b0;
                end
            end else if (state == ACCESS) begin
                cnt <= cnt - 1'b1;
                if (ram_op) begin
                    state       <= RESP;
                    wbPc        <= op.pc;
                    wbROBNum    <= op.rob;
                    wbDestReg   <= op.ls == OP_STORE ? 6'd0 : op.dest;
                    wbData      <= op.ls == OP_STORE ? 32'd0 : ld_data;
                    wbIsStore   <= op.ls;
                    misalignErr <= misalignErr | (op.size == SIZE_WORD && lane != 2'b00);
                end
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (ram_op && op.ls == OP_STORE) begin
            if (op.size == SIZE_WORD) ram[idx] <= op.swData;
            else ram[idx][{lane, 3'b000} +: 8] <= op.swData[7:0];
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for the memory access stage
module tb_mem_access_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic        st;
        int          e;
    } wb_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] inPc = '0;
    logic [5:0]  inROBNum = '0;
    logic [5:0]  inDestReg = '0;
    logic [31:0] inAddr = '0;
    logic        inLoadStore = 1'b0;
    logic        inSize = 1'b0;
    logic [31:0] inSwData = '0;
    logic        inFromLSQ = 1'b0;
    logic [31:0] inLwData = '0;
    logic        wbValid, wbIsStore, fifoFull, overflowErr, misalignErr;
    logic [31:0] wbPc, wbData;
    logic [5:0]  wbROBNum, wbDestReg;

    int compares = 0;
    int fails = 0;
    int edge_cnt = 0;
    int last_n = 0;
    wb_t q[$];
    wb_t r;

    mem_access_stage dut (
        .clk(clk), .rstn(rstn), .inValid(inValid), .inPc(inPc), .inROBNum(inROBNum),
        .inDestReg(inDestReg), .inAddr(inAddr), .inLoadStore(inLoadStore), .inSize(inSize),
        .inSwData(inSwData), .inFromLSQ(inFromLSQ), .inLwData(inLwData),
        .wbValid(wbValid), .wbPc(wbPc), .wbROBNum(wbROBNum), .wbDestReg(wbDestReg),
        .wbData(wbData), .wbIsStore(wbIsStore), .fifoFull(fifoFull),
        .overflowErr(overflowErr), .misalignErr(misalignErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;
    always @(negedge clk) begin
        if (wbValid) q.push_back('{pc: wbPc, data: wbData, rob: wbROBNum, dest: wbDestReg, st: wbIsStore, e: edge_cnt});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ls, input logic sz, input logic fwd, input logic [31:0] addr,
                         input logic [31:0] sw, input logic [31:0] lw, input logic [5:0] rob);
        @(negedge clk);
        inValid = 1'b1; inLoadStore = ls; inSize = sz; inFromLSQ = fwd; inAddr = addr;
        inSwData = sw; inLwData = lw; inROBNum = rob; inDestReg = rob + 6'd1;
        inPc = 32'h1000 + {24'd0, rob, 2'b00};
        @(posedge clk);
        #1;
        last_n = edge_cnt;
        inValid = 1'b0;
    endtask

    task automatic get_wb(output wb_t w);
        int t = 0;
        while (q.size() == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        compares++;
        assert (q.size() != 0) else begin
            fails++;
            $error("FAIL wb_timeout observed=none expected=wbValid");
        end
        w = q.size() != 0 ? q.pop_front() : '{pc: '0, data: '0, rob: '0, dest: '0, st: 1'b0, e: 0};
    endtask

    task automatic expect_wb(input string tag, input int lat, input logic [31:0] data,
                             input logic [5:0] rob, input logic st);
        wb_t w;
        get_wb(w);
        check({tag, "_data"}, w.data, data);
        check({tag, "_rob"}, {26'd0, w.rob}, {26'd0, rob});
        check({tag, "_dest"}, {26'd0, w.dest}, st ? 32'd0 : {26'd0, rob + 6'd1});
        check({tag, "_st"}, {31'd0, w.st}, {31'd0, st});
        check({tag, "_pc"}, w.pc, 32'h1000 + {24'd0, rob, 2'b00});
        if (lat >= 0) check({tag, "_lat"}, w.e - last_n, lat);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wbValid", {31'd0, wbValid}, 0);
        check("rst_wbData", wbData, 0);
        check("rst_full", {31'd0, fifoFull}, 0);
        check("rst_ovf", {31'd0, overflowErr}, 0);
        check("rst_mis", {31'd0, misalignErr}, 0);
        rstn = 1'b1;

        issue(1, 0, 0, 32'h100, 32'hDEADBEEF, 0, 6'd1);
        expect_wb("sw100", 3, 32'h0, 6'd1, 1);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd2);
        expect_wb("lw100", 3, 32'hDEADBEEF, 6'd2, 0);

        issue(1, 0, 0, 32'h40, 32'h11223344, 0, 6'd3);
        expect_wb("sw40", 3, 32'h0, 6'd3, 1);
        issue(1, 1, 0, 32'h42, 32'hABCDEF80, 0, 6'd4);
        expect_wb("sb42", 3, 32'h0, 6'd4, 1);
        issue(0, 1, 0, 32'h42, 0, 0, 6'd5);
        expect_wb("lb42", 3, 32'hFFFFFF80, 6'd5, 0);
        issue(0, 0, 0, 32'h40, 0, 0, 6'd6);
        expect_wb("lw40", 3, 32'h11803344, 6'd6, 0);
        issue(0, 1, 0, 32'h40, 0, 0, 6'd8);
        expect_wb("lb40", 3, 32'h00000044, 6'd8, 0);

        issue(0, 0, 1, 32'h102, 0, 32'h5A5A0001, 6'd7);
        expect_wb("fwd", 1, 32'h5A5A0001, 6'd7, 0);
        check("fwd_nomis", {31'd0, misalignErr}, 0);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd9);
        expect_wb("ram_untouched", 3, 32'hDEADBEEF, 6'd9, 0);

        issue(0, 0, 0, 32'h100, 0, 0, 6'd10);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd11);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd12);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd13);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd14);
        check("burst_full", {31'd0, fifoFull}, 1);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd15);
        check("burst_full_pop_ok", {31'd0, overflowErr}, 0);
        issue(0, 0, 0, 32'h100, 0, 0, 6'd16);
        check("burst_ovf", {31'd0, overflowErr}, 1);
        for (int i = 10; i <= 15; i++) expect_wb("burst", -1, 32'hDEADBEEF, 6'(i), 0);
        repeat (20) @(negedge clk);
        check("burst_dropped", q.size(), 0);

        issue(0, 0, 0, 32'h102, 0, 0, 6'd17);
        expect_wb("lw102", 3, 32'hDEADBEEF, 6'd17, 0);
        check("mis_set", {31'd0, misalignErr}, 1);
        issue(1, 0, 0, 32'h200, 32'h0BADF00D, 0, 6'd18);
        expect_wb("sw200", 3, 32'h0, 6'd18, 1);
        issue(1, 0, 0, 32'h1000, 32'hCAFEF00D, 0, 6'd19);
        expect_wb("sw_wrap", 3, 32'h0, 6'd19, 1);
        issue(0, 0, 0, 32'h0, 0, 0, 6'd22);
        expect_wb("lw_wrap", 3, 32'hCAFEF00D, 6'd22, 0);

        issue(1, 0, 0, 32'h200, 32'h12345678, 0, 6'd20);
        issue(0, 0, 0, 32'h200, 0, 0, 6'd21);
        rstn = 1'b0;
        #1;
        check("mid_rst_wbValid", {31'd0, wbValid}, 0);
        check("mid_rst_wbData", wbData, 0);
        check("mid_rst_wbPc", wbPc, 0);
        check("mid_rst_rob", {26'd0, wbROBNum}, 0);
        check("mid_rst_ovf", {31'd0, overflowErr}, 0);
        check("mid_rst_mis", {31'd0, misalignErr}, 0);
        check("mid_rst_full", {31'd0, fifoFull}, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_no_wb", q.size(), 0);
        issue(0, 0, 0, 32'h200, 0, 0, 6'd23);
        expect_wb("post_rst_lw", 3, 32'h0BADF00D, 6'd23, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
